// File: rtl/ycr_dmem_rt_pkg.sv
// ycr_dmem_rt_pkg: memory-interface enums, tag sizing and the address-decode priority helper for the DMEM router
package ycr_dmem_rt_pkg;
  typedef enum logic [1:0] {
    YCR_MEM_RESP_NOTRDY = 2'b00,
    YCR_MEM_RESP_RDY_OK = 2'b01,
    YCR_MEM_RESP_RDY_ER = 2'b10
  } type_ycr_mem_resp_e;
  localparam int RT_MAX_PORTS = 8;
  localparam int RT_TAG_MAX_W = $clog2(RT_MAX_PORTS + 1);
  typedef logic [RT_TAG_MAX_W-1:0] rt_tag_t;
  // Lowest-index hit wins; a miss yields port 0, or the LOCAL tag (== nports) when decode errors are enabled.
  function automatic rt_tag_t rt_decode(input logic [RT_MAX_PORTS-1:1] hit, input int nports, input logic local_en);
    rt_decode = local_en ? rt_tag_t'(nports) : '0;
    for (int i = RT_MAX_PORTS - 1; i >= 1; i--)
      if (hit[i]) rt_decode = rt_tag_t'(i);
  endfunction
endpackage

// File: rtl/ycr_dmem_rt_tagfifo.sv
// ycr_dmem_rt_tagfifo: issue-order tag FIFO (push/pop/full/empty/head, simultaneous push+pop when non-empty)
module ycr_dmem_rt_tagfifo #(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    wr_d  = push_i ? inc(wr_q) : wr_q;
    rd_d  = pop_i ? inc(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= data_i;
  assign head_o  = mem_q[rd_q];
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/ycr_dmem_router_np.sv
// ycr_dmem_router_np: N-port DMEM router; address decode, in-order issue gating via tag FIFO, zero-latency response mux
// Ports: clk, rst_n (async active-low); core side dmem_req/ack/cmd/width/addr/wdata/rdata/resp;
// slave side per-port port_req/port_req_ack, broadcast cmd/width/addr/wdata, packed port_rdata/port_resp.
// Build option: define YCR_DMEM_RT_DECERR_EN to answer unmapped addresses locally with RDY_ER instead of routing to port 0.
module ycr_dmem_router_np
  import ycr_dmem_rt_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int OUTSTD = 2,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter logic [NPORTS-1:1][AW-1:0] ADDR_MASK    = {(NPORTS-1){{AW{1'b1}}}},
  parameter logic [NPORTS-1:1][AW-1:0] ADDR_PATTERN = {(NPORTS-1){{AW{1'b1}}}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dmem_req,
  output logic                 dmem_req_ack,
  input  logic                 dmem_cmd,
  input  logic [1:0]           dmem_width,
  input  logic [AW-1:0]        dmem_addr,
  input  logic [DW-1:0]        dmem_wdata,
  output logic [DW-1:0]        dmem_rdata,
  output logic [1:0]           dmem_resp,
  output logic [NPORTS-1:0]    port_req,
  input  logic [NPORTS-1:0]    port_req_ack,
  output logic                 port_cmd,
  output logic [1:0]           port_width,
  output logic [AW-1:0]        port_addr,
  output logic [DW-1:0]        port_wdata,
  input  logic [NPORTS*DW-1:0] port_rdata,
  input  logic [NPORTS*2-1:0]  port_resp
);
  localparam int TW = $clog2(NPORTS + 1);
  localparam logic [TW-1:0] TAG_LOCAL = TW'(NPORTS);
`ifdef YCR_DMEM_RT_DECERR_EN
  localparam logic DECERR_EN = 1'b1;
`else
  localparam logic DECERR_EN = 1'b0;
`endif
  logic [RT_MAX_PORTS-1:1] hit;
  logic [TW-1:0]           tag, head, last_sel_q, last_sel_d;
  logic [NPORTS-1:0]       oh;
  logic [DW-1:0]           rdata_sel;
  logic [1:0]              resp_sel;
  logic                    full, empty, issue, push, pop, head_local;
  always_comb begin
    hit = '0;
    for (int i = 1; i < NPORTS; i++)
      hit[i] = (dmem_addr & ADDR_MASK[i]) == ADDR_PATTERN[i];
    tag = TW'(rt_decode(hit, NPORTS, DECERR_EN));
  end
  // A port change waits for the FIFO to drain so responses can never return out of order.
  always_comb begin
    oh = '0;
    for (int i = 0; i < NPORTS; i++)
      oh[i] = tag == TW'(i);
    issue        = empty | (~full & (tag == last_sel_q));
    port_req     = (issue & dmem_req) ? oh : '0;
    dmem_req_ack = dmem_req & issue & ((tag == TAG_LOCAL) | |(port_req_ack & oh));
    push         = dmem_req_ack;
    last_sel_d   = push ? tag : last_sel_q;
  end
  always_comb begin
    rdata_sel = '0;
    resp_sel  = YCR_MEM_RESP_NOTRDY;
    for (int i = 0; i < NPORTS; i++)
      if (head == TW'(i)) begin
        rdata_sel = port_rdata[i*DW +: DW];
        resp_sel  = port_resp[i*2 +: 2];
      end
    head_local = head == TAG_LOCAL;
    dmem_resp  = empty ? YCR_MEM_RESP_NOTRDY : head_local ? YCR_MEM_RESP_RDY_ER : resp_sel;
    dmem_rdata = (empty | head_local) ? '0 : rdata_sel;
    pop        = dmem_resp != YCR_MEM_RESP_NOTRDY;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_sel_q <= '0;
    else last_sel_q <= last_sel_d;
  ycr_dmem_rt_tagfifo #(.DEPTH(OUTSTD), .W(TW)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .data_i (tag),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );
  assign port_cmd   = dmem_cmd;
  assign port_width = dmem_width;
  assign port_addr  = dmem_addr;
  assign port_wdata = dmem_wdata;
endmodule

// File: tb/tb_ycr_dmem_router_np.sv
// tb_ycr_dmem_router_np: directed self-checking bench for the 4-port, 2-outstanding DMEM router
module tb_ycr_dmem_router_np;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dmem_req = 1'b0;
  logic          dmem_req_ack;
  logic          dmem_cmd = 1'b0;
  logic [1:0]    dmem_width = 2'b10;
  logic [31:0]   dmem_addr = '0;
  logic [31:0]   dmem_wdata = '0;
  logic [31:0]   dmem_rdata;
  logic [1:0]    dmem_resp;
  logic [3:0]    port_req;
  logic [3:0]    port_req_ack = '0;
  logic          port_cmd;
  logic [1:0]    port_width;
  logic [31:0]   port_addr;
  logic [31:0]   port_wdata;
  logic [127:0]  port_rdata = '0;
  logic [7:0]    port_resp = '0;
  int checks = 0;
  int failures = 0;
  ycr_dmem_router_np #(
    .NPORTS(4), .OUTSTD(2), .AW(32), .DW(32),
    .ADDR_MASK   ({32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
    .ADDR_PATTERN({32'h0000_0000, 32'h0002_0000, 32'h0001_0000})
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .port_req(port_req), .port_req_ack(port_req_ack), .port_cmd(port_cmd), .port_width(port_width),
    .port_addr(port_addr), .port_wdata(port_wdata), .port_rdata(port_rdata), .port_resp(port_resp)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rsp(input int p, input logic [1:0] r, input logic [31:0] d);
    port_resp[p*2 +: 2]   = r;
    port_rdata[p*32 +: 32] = d;
  endtask
  task automatic req(input logic [31:0] a, input logic [3:0] acks);
    dmem_req     = 1'b1;
    dmem_addr    = a;
    port_req_ack = acks;
  endtask
  task automatic idle();
    dmem_req     = 1'b0;
    port_req_ack = '0;
  endtask
  initial begin
    tick();
    tick();
    check("rst_resp", 32'(dmem_resp), 32'h0);
    check("rst_rdata", dmem_rdata, 32'h0);
    check("rst_preq", 32'(port_req), 32'h0);
    check("rst_ack", 32'(dmem_req_ack), 32'h0);
    rst_n = 1'b1;
    tick();
    // mid-run reset discards an in-flight tag
    req(32'h0001_0000, 4'b0010);
    #1;
    check("mr_preq", 32'(port_req), 32'h2);
    check("mr_ack", 32'(dmem_req_ack), 32'h1);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    rsp(1, 2'b01, 32'hDEAD_BEEF);
    #1;
    check("mr_late_resp", 32'(dmem_resp), 32'h0);
    check("mr_late_rdata", dmem_rdata, 32'h0);
    check("mr_idle_preq", 32'(port_req), 32'h0);
    rsp(1, 2'b00, 32'h0);
    tick();
    // pipelined reads to port 1
    req(32'h0001_0000, 4'b0010);
    #1;
    check("pl_ack0", 32'(dmem_req_ack), 32'h1);
    check("pl_resp0_none", 32'(dmem_resp), 32'h0);
    tick();
    req(32'h0001_0004, 4'b0010);
    rsp(1, 2'b01, 32'h1111_1111);
    #1;
    check("pl_ack1", 32'(dmem_req_ack), 32'h1);
    check("pl_resp0", 32'(dmem_resp), 32'h1);
    check("pl_rdata0", dmem_rdata, 32'h1111_1111);
    check("pl_bcast_addr", port_addr, 32'h0001_0004);
    tick();
    idle();
    rsp(1, 2'b01, 32'h2222_2222);
    #1;
    check("pl_resp1", 32'(dmem_resp), 32'h1);
    check("pl_rdata1", dmem_rdata, 32'h2222_2222);
    tick();
    rsp(1, 2'b00, 32'h0);
    #1;
    check("pl_drained", 32'(dmem_resp), 32'h0);
    // port switch stalls until port 1 has responded
    req(32'h0001_0000, 4'b0010);
    tick();
    req(32'h0002_0000, 4'b0110);
    #1;
    check("sw_stall_preq", 32'(port_req), 32'h0);
    check("sw_stall_ack", 32'(dmem_req_ack), 32'h0);
    tick();
    tick();
    rsp(1, 2'b01, 32'h0000_0033);
    #1;
    check("sw_stall_last", 32'(port_req), 32'h0);
    check("sw_p1_rdata", dmem_rdata, 32'h0000_0033);
    tick();
    rsp(1, 2'b00, 32'h0);
    #1;
    check("sw_issue_preq", 32'(port_req), 32'h4);
    check("sw_issue_ack", 32'(dmem_req_ack), 32'h1);
    tick();
    idle();
    rsp(2, 2'b01, 32'h0000_0044);
    #1;
    check("sw_p2_rdata", dmem_rdata, 32'h0000_0044);
    tick();
    rsp(2, 2'b00, 32'h0);
    // full: two in flight, third request held off even when a pop coincides
    req(32'h0001_0000, 4'b0010);
    tick();
    req(32'h0001_0004, 4'b0010);
    tick();
    req(32'h0001_0008, 4'b0010);
    #1;
    check("full_ack", 32'(dmem_req_ack), 32'h0);
    check("full_preq", 32'(port_req), 32'h0);
    tick();
    rsp(1, 2'b01, 32'h0000_0055);
    #1;
    check("full_pop_ack", 32'(dmem_req_ack), 32'h0);
    check("full_pop_rdata", dmem_rdata, 32'h0000_0055);
    tick();
    rsp(1, 2'b00, 32'h0);
    #1;
    check("full_after_ack", 32'(dmem_req_ack), 32'h1);
    tick();
    idle();
    rsp(1, 2'b01, 32'h0000_0066);
    #1;
    check("full_d1", dmem_rdata, 32'h0000_0066);
    tick();
    rsp(1, 2'b01, 32'h0000_0077);
    #1;
    check("full_d2", dmem_rdata, 32'h0000_0077);
    tick();
    rsp(1, 2'b00, 32'h0);
    #1;
    check("full_drained", 32'(dmem_resp), 32'h0);
    // error response from port 2 pops like OK
    dmem_cmd   = 1'b1;
    dmem_wdata = 32'hCAFE_0001;
    req(32'h0002_0000, 4'b0100);
    #1;
    check("er_wdata", port_wdata, 32'hCAFE_0001);
    check("er_cmd", 32'(port_cmd), 32'h1);
    tick();
    idle();
    dmem_cmd = 1'b0;
    rsp(2, 2'b10, 32'h0000_0BAD);
    #1;
    check("er_resp", 32'(dmem_resp), 32'h2);
    check("er_rdata", dmem_rdata, 32'h0000_0BAD);
    tick();
    rsp(2, 2'b00, 32'h0);
    #1;
    check("er_popped", 32'(dmem_resp), 32'h0);
    req(32'h0001_0000, 4'b0010);
    #1;
    check("er_next_ack", 32'(dmem_req_ack), 32'h1);
    tick();
    idle();
    rsp(1, 2'b01, 32'h0000_0099);
    #1;
    check("er_next_rdata", dmem_rdata, 32'h0000_0099);
    tick();
    rsp(1, 2'b00, 32'h0);
    // overlapping regions: 0x00050000 only hits port 3; no ack offered, so nothing is pushed
    req(32'h0005_0000, 4'b0000);
    #1;
    check("dec_p3_preq", 32'(port_req), 32'h8);
    check("dec_p3_noack", 32'(dmem_req_ack), 32'h0);
    tick();
    // unmapped address
    req(32'hF000_0000, 4'b1111);
    rsp(0, 2'b00, 32'h0);
    #1;
`ifdef YCR_DMEM_RT_DECERR_EN
    check("un_preq", 32'(port_req), 32'h0);
    check("un_ack", 32'(dmem_req_ack), 32'h1);
    tick();
    idle();
    rsp(0, 2'b01, 32'h0000_0123);
    #1;
    check("un_resp", 32'(dmem_resp), 32'h2);
    check("un_rdata", dmem_rdata, 32'h0);
`else
    check("un_preq", 32'(port_req), 32'h1);
    check("un_ack", 32'(dmem_req_ack), 32'h1);
    tick();
    idle();
    rsp(0, 2'b01, 32'h0000_0123);
    #1;
    check("un_resp", 32'(dmem_resp), 32'h1);
    check("un_rdata", dmem_rdata, 32'h0000_0123);
`endif
    tick();
    rsp(0, 2'b00, 32'h0);
    #1;
    check("un_popped", 32'(dmem_resp), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
